// File: rtl/inst_prefetch_queue_if.sv
// Fetch/IF-ID bundle of the instruction prefetch queue: imem address/data, head handshake, redirect, status.
// master = the queue itself, slave = the surrounding fetch/decode logic.
interface inst_prefetch_queue_if #(
    parameter int CW = 3
);
    logic [31:0]   Fetch_Adrs;
    logic [31:0]   Inst_In;
    logic [31:0]   Inst_Out;
    logic [31:0]   PC4_Out;
    logic          Valid_Out;
    logic          Ready_In;
    logic          Redirect;
    logic [31:0]   Redirect_Adrs;
    logic [CW-1:0] Occupancy;
    logic [31:0]   Stall_Cycles;
    logic [31:0]   Flush_Count;

    modport master (
        output Fetch_Adrs, Inst_Out, PC4_Out, Valid_Out, Occupancy, Stall_Cycles, Flush_Count,
        input  Inst_In, Ready_In, Redirect, Redirect_Adrs
    );

    modport slave (
        input  Fetch_Adrs, Inst_Out, PC4_Out, Valid_Out, Occupancy, Stall_Cycles, Flush_Count,
        output Inst_In, Ready_In, Redirect, Redirect_Adrs
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns fetch PC, buffers {inst, pc+4}; fetch-to-head latency 1 cycle.
// Fetch stalls when full unless the head dequeues that cycle; PREFETCH_STATS_EN adds stall/flush counters.
module inst_prefetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          CW       = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    inst_prefetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } entry_t;

    entry_t        r_mem [DEPTH];
    entry_t        r_last;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fetch_pc;

    logic          w_full;
    logic          w_valid;
    logic          w_deq;
    logic          w_enq;
    logic [31:0]   w_pc4;
    logic [31:0]   w_redirect_pc;
    entry_t        w_head;

    assign w_full        = (r_count == CW'(DEPTH));
    assign w_valid       = (r_count != '0);
    assign w_deq         = w_valid && bus.Ready_In;
    assign w_enq         = !bus.Redirect && (!w_full || w_deq);
    assign w_pc4         = r_fetch_pc + 32'd4;
    assign w_redirect_pc = bus.Redirect_Adrs & ~32'h0000_0003;
    assign w_head        = r_mem[r_head];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (bus.Redirect) begin
            r_fetch_pc <= w_redirect_pc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_tail     <= r_tail + 1'b1;
                r_fetch_pc <= w_pc4;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is not reset; only entries covered by r_count are ever observed.
    always_ff @(posedge Clk) begin
        if (!Rst && w_enq) begin
            r_mem[r_tail] <= {bus.Inst_In, w_pc4};
        end
    end

    // Shadow of the displayed head so outputs hold once the queue drains.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_last <= '0;
        end else if (w_valid) begin
            r_last <= w_head;
        end
    end

    assign bus.Fetch_Adrs = r_fetch_pc;
    assign bus.Valid_Out  = w_valid;
    assign bus.Occupancy  = r_count;
    assign bus.Inst_Out   = w_valid ? w_head.inst : r_last.inst;
    assign bus.PC4_Out    = w_valid ? w_head.pc4  : r_last.pc4;

`ifdef PREFETCH_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic        w_discard;

    // A head delivered in the redirect cycle is not a discarded entry.
    assign w_discard = bus.Redirect && (r_count > (w_deq ? CW'(1) : CW'(0)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_full && !w_deq && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_discard && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign bus.Stall_Cycles = r_stall_cycles;
    assign bus.Flush_Count  = r_flush_count;
`else
    assign bus.Stall_Cycles = 32'd0;
    assign bus.Flush_Count  = 32'd0;
`endif
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed phases drive the queue, a negedge monitor pops a scoreboard
// on every head handshake; direct checks cover occupancy, fetch address and counters.
module tb_inst_prefetch_queue;
`ifdef PREFETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic Clk;
    logic Rst;
    int   n_tests;
    int   n_fail;
    logic [63:0] exp_q[$];

    inst_prefetch_queue_if #(.CW(3)) bus ();

    inst_prefetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4),
        .CW       (3)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Asynchronous instruction memory: word i holds 32'h1000_0000 + i.
    always_comb begin
        bus.Inst_In = 32'h1000_0000 + {2'b00, bus.Fetch_Adrs[31:2]};
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc4);
        exp_q.push_back({inst, pc4});
    endtask

    // Monitor: every head handshake must match the next expected entry.
    always @(negedge Clk) begin
        if (!Rst && bus.Valid_Out && bus.Ready_In) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL hs_unexpected: got inst %h pc4 %h, expected no handshake",
                         bus.Inst_Out, bus.PC4_Out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("hs_inst", bus.Inst_Out, e[63:32]);
                chk("hs_pc4", bus.PC4_Out, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        Rst               = 1'b1;
        bus.Ready_In      = 1'b0;
        bus.Redirect      = 1'b0;
        bus.Redirect_Adrs = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_occ",   32'(bus.Occupancy), 32'd0);
        chk("rst_valid", 32'(bus.Valid_Out), 32'd0);
        chk("rst_fetch", bus.Fetch_Adrs, 32'h0);
        chk("rst_inst",  bus.Inst_Out, 32'h0);
        chk("rst_pc4",   bus.PC4_Out, 32'h0);
        chk("rst_stall", bus.Stall_Cycles, 32'h0);
        chk("rst_flush", bus.Flush_Count, 32'h0);

        // Fill with IF/ID stalled
        Rst = 1'b0;
        tick();
        chk("fill_first_valid", 32'(bus.Valid_Out), 32'd1);
        repeat (5) tick();
        chk("fill_occ",   32'(bus.Occupancy), 32'd4);
        chk("fill_fetch", bus.Fetch_Adrs, 32'h10);
        chk("fill_inst",  bus.Inst_Out, 32'h1000_0000);
        chk("fill_pc4",   bus.PC4_Out, 32'h4);
        chk("fill_stall", bus.Stall_Cycles, STATS ? 32'd2 : 32'd0);

        // Full plus simultaneous handshake
        push(32'h1000_0000, 32'h4);
        bus.Ready_In = 1'b1;
        tick();
        bus.Ready_In = 1'b0;
        chk("full_hs_occ",   32'(bus.Occupancy), 32'd4);
        chk("full_hs_pc4",   bus.PC4_Out, 32'h8);
        chk("full_hs_inst",  bus.Inst_Out, 32'h1000_0001);
        chk("full_hs_fetch", bus.Fetch_Adrs, 32'h14);
        chk("full_hs_stall", bus.Stall_Cycles, STATS ? 32'd2 : 32'd0);

        // Streaming
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        bus.Ready_In = 1'b1;
        push(32'h1000_0000, 32'h04);
        push(32'h1000_0001, 32'h08);
        push(32'h1000_0002, 32'h0C);
        push(32'h1000_0003, 32'h10);
        push(32'h1000_0004, 32'h14);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stream_occ", 32'(bus.Occupancy), 32'd1);
        end
        bus.Ready_In = 1'b0;

        // Redirect with 3 entries queued and head delivered
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        repeat (3) tick();
        chk("redir_pre_occ",   32'(bus.Occupancy), 32'd3);
        chk("redir_pre_fetch", bus.Fetch_Adrs, 32'hC);
        push(32'h1000_0000, 32'h4);
        bus.Redirect      = 1'b1;
        bus.Redirect_Adrs = 32'h0000_0203;
        bus.Ready_In      = 1'b1;
        tick();
        bus.Redirect = 1'b0;
        bus.Ready_In = 1'b0;
        chk("redir_valid",     32'(bus.Valid_Out), 32'd0);
        chk("redir_occ",       32'(bus.Occupancy), 32'd0);
        chk("redir_fetch",     bus.Fetch_Adrs, 32'h200);
        chk("redir_hold_inst", bus.Inst_Out, 32'h1000_0000);
        chk("redir_hold_pc4",  bus.PC4_Out, 32'h4);
        tick();
        chk("redir_new_valid", 32'(bus.Valid_Out), 32'd1);
        chk("redir_new_inst",  bus.Inst_Out, 32'h1000_0080);
        chk("redir_new_pc4",   bus.PC4_Out, 32'h204);
        chk("redir_new_fetch", bus.Fetch_Adrs, 32'h204);
        chk("redir_flush",     bus.Flush_Count, STATS ? 32'd1 : 32'd0);

        // Wrap of fetch PC and pointers
        bus.Redirect      = 1'b1;
        bus.Redirect_Adrs = 32'hFFFF_FFF8;
        tick();
        bus.Redirect = 1'b0;
        chk("wrap_flush", bus.Flush_Count, STATS ? 32'd2 : 32'd0);
        chk("wrap_fetch", bus.Fetch_Adrs, 32'hFFFF_FFF8);
        push(32'h4FFF_FFFE, 32'hFFFF_FFFC);
        push(32'h4FFF_FFFF, 32'h0000_0000);
        push(32'h1000_0000, 32'h0000_0004);
        push(32'h1000_0001, 32'h0000_0008);
        push(32'h1000_0002, 32'h0000_000C);
        bus.Ready_In = 1'b1;
        repeat (6) tick();
        bus.Ready_In = 1'b0;
        chk("wrap_head_pc4", bus.PC4_Out, 32'h10);
        chk("wrap_fetch_end", bus.Fetch_Adrs, 32'h10);

        // Reset mid-stream overrides redirect and ready
        repeat (2) tick();
        chk("mid_pre_occ", 32'(bus.Occupancy), 32'd3);
        Rst               = 1'b1;
        bus.Redirect      = 1'b1;
        bus.Redirect_Adrs = 32'h0000_1000;
        bus.Ready_In      = 1'b1;
        tick();
        Rst          = 1'b0;
        bus.Redirect = 1'b0;
        bus.Ready_In = 1'b0;
        chk("mid_occ",   32'(bus.Occupancy), 32'd0);
        chk("mid_valid", 32'(bus.Valid_Out), 32'd0);
        chk("mid_fetch", bus.Fetch_Adrs, 32'h0);
        chk("mid_stall", bus.Stall_Cycles, 32'h0);
        chk("mid_flush", bus.Flush_Count, 32'h0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
